// File: rtl/chnlnk_evt_sched.sv
// Event scheduler for the channel-link readout path: queues accepted L1A events with their
// sample counts and tracks framing progress of the head event from the frame FSM state code.
module chnlnk_evt_sched #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned NSAMP_W    = 5,
    parameter int unsigned L1A_W      = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  L1A_MATCH,
    input  logic [NSAMP_W-1:0]    NSAMP,
    input  logic [2:0]            FRM_STATE,
    output logic                  L1A_BUF_MT,
    output logic                  END_EVT,
    output logic [DEPTH_LOG2:0]   EVT_CNT,
    output logic [L1A_W-1:0]      HEAD_L1A_NUM,
    output logic [NSAMP_W-1:0]    SMP_IDX,
    output logic                  OVFL,
    output logic                  PROTO_ERR
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [2:0] STRT_SAMPLE = 3'b011;
    localparam logic [2:0] LAST_WORD   = 3'b001;

    logic [L1A_W-1:0]      mem_l1a [DEPTH];
    logic [NSAMP_W-1:0]    mem_ns  [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [L1A_W-1:0]      l1a_cnt_q, l1a_cnt_d;
    logic [NSAMP_W-1:0]    smp_idx_q, smp_idx_d;
    logic                  end_evt_q, end_evt_d;
    logic                  ovfl_q, ovfl_d;
    logic                  proto_q, proto_d;

    logic                  strt, last, not_empty, pop, push;
    logic [NSAMP_W-1:0]    nsamp_eff, head_ns_next;

    always_comb begin
        strt      = (FRM_STATE == STRT_SAMPLE);
        last      = (FRM_STATE == LAST_WORD);
        not_empty = (count_q != '0);
        pop       = last && not_empty;
        push      = L1A_MATCH && ((count_q != FULL_CNT) || pop);
        nsamp_eff = (NSAMP == '0) ? NSAMP_W'(1) : NSAMP;

        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        l1a_cnt_d = L1A_MATCH ? l1a_cnt_q + 1'b1 : l1a_cnt_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        smp_idx_d = smp_idx_q;
        if (pop) begin
            smp_idx_d = '0;
        end else if (strt && not_empty && (smp_idx_q != '1)) begin
            smp_idx_d = smp_idx_q + 1'b1;
        end

        // Pointers meet only when the entry being written becomes the head next cycle.
        head_ns_next = (push && (wr_ptr_q == rd_ptr_d)) ? nsamp_eff : mem_ns[rd_ptr_d];
        end_evt_d    = (count_d != '0) && (smp_idx_d >= head_ns_next);

        ovfl_d  = ovfl_q || (L1A_MATCH && !push);
        proto_d = proto_q || ((strt || last) && !not_empty);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            l1a_cnt_q <= '0;
            smp_idx_q <= '0;
            end_evt_q <= 1'b0;
            ovfl_q    <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            l1a_cnt_q <= l1a_cnt_d;
            smp_idx_q <= smp_idx_d;
            end_evt_q <= end_evt_d;
            ovfl_q    <= ovfl_d;
            proto_q   <= proto_d;
        end
    end

    // Storage needs no reset; the occupancy count decides what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_l1a[wr_ptr_q] <= l1a_cnt_q;
            mem_ns[wr_ptr_q]  <= nsamp_eff;
        end
    end

    always_comb begin
        L1A_BUF_MT   = (count_q == '0);
        END_EVT      = end_evt_q;
        EVT_CNT      = count_q;
        HEAD_L1A_NUM = (count_q == '0) ? '0 : mem_l1a[rd_ptr_q];
        SMP_IDX      = smp_idx_q;
        OVFL         = ovfl_q;
        PROTO_ERR    = proto_q;
    end

endmodule
